dm74ls08_quad_and: RTL and testbench
====================================

Name: dm74ls08_quad_and

Overview:
- Synthesizable model of the DM74LS08 quadruple 2-input AND gate for the board-level logic library.
- Four independent gates: output nY = nA AND nB.
- An optional clocked propagation-delay pipeline emulates TTL gate delay inside the synchronous FPGA fabric.
- The default configuration is purely combinational and is a drop-in replacement for the discrete part.

Parameters:
- DELAY_CYCLES, 0, number of clk cycles between an input change and the matching output change. 0 means purely combinational. Legal range is 0..16.

Ports:
- clk  input  1  system clock; used only when DELAY_CYCLES >= 1
- rst_n  input  1  reset, asynchronous, active-low; clears the delay pipeline
- _1A  input  1  gate 1 input A
- _1B  input  1  gate 1 input B
- _1Y  output  1  gate 1 output
- _2A  input  1  gate 2 input A
- _2B  input  1  gate 2 input B
- _2Y  output  1  gate 2 output
- _3A  input  1  gate 3 input A
- _3B  input  1  gate 3 input B
- _3Y  output  1  gate 3 output
- _4A  input  1  gate 4 input A
- _4B  input  1  gate 4 input B
- _4Y  output  1  gate 4 output

Interface decision: one clock (clk); reset rst_n is asynchronous and active-low.

Behaviour:
- Truth table, per gate n in 1..4: A=0,B=0 gives Y=0; A=0,B=1 gives Y=0; A=1,B=0 gives Y=0; A=1,B=1 gives Y=1.
- Gates are fully independent. No cross-coupling between gates and no shared enable.

DELAY_CYCLES = 0:
- nY = nA & nB continuously, with zero clock latency.
- clk and rst_n have no effect on the outputs, including while rst_n = 0.

DELAY_CYCLES = N >= 1:
- Each gate has an N-stage shift register. Stage 0 captures nA & nB on every rising clk edge.
- nY is driven by stage N-1. Output at edge k equals the AND of the inputs sampled at edge k-N+1, i.e. N cycles of latency.
- rst_n low asynchronously clears all stages of all gates, so every Y goes 0 immediately, without a clock edge. All stages are held at 0 while rst_n is low.
- On rst_n release, the first capture occurs at the next rising edge. Outputs stay 0 until N edges have passed.
- Reset asserted mid-operation discards all in-flight values. No partial pipeline survives.
- Input glitches narrower than one clk period between edges are not captured. This pulse-swallowing is required.
- No X-propagation suppression: X/Z on an input propagates per standard Verilog & semantics.
- No other state, no handshake, no overflow or wrap conditions.

Test Plan:
- DELAY_CYCLES=0: drive all four gates through (A,B) = 00, 01, 10, 11, 10 time units apart. Each Y must read 0, 0, 0, 1 after settling, with all four gates identical.
- DELAY_CYCLES=0, gate independence: set gate1=11, gate2=01, gate3=10, gate4=00. Outputs must be _1Y=1, _2Y=0, _3Y=0, _4Y=0; then swap the patterns and confirm the outputs follow.
- DELAY_CYCLES=0, reset transparency: hold rst_n=0 with all inputs 1. All Y must be 1.
- DELAY_CYCLES=2, latency: all inputs go 1 just after edge 0. All Y must be 0 after edge 1 and 1 after edge 2; after returning the inputs to 0, Y must fall 2 edges later.
- DELAY_CYCLES=2, async reset: with all Y=1, pull rst_n low between edges. All Y must go 0 immediately without a clock edge. Release rst_n with inputs still 1: Y must stay 0 for the first edge and become 1 after the second edge.
- DELAY_CYCLES=1, glitch: pulse _1A high for half a clk period between edges with _1B=1. _1Y must remain 0.

Source files
------------

// File: rtl/dm74ls08_quad_and.sv
// dm74ls08_quad_and: DM74LS08 quad 2-input AND gate with optional clocked propagation delay
//   DELAY_CYCLES  0 = purely combinational; N (1..16) = N clk cycles of latency per gate
//   clk           pipeline clock, ignored when DELAY_CYCLES = 0
//   rst_n         asynchronous active-low clear of the pipeline, ignored when DELAY_CYCLES = 0
//   _nA, _nB      gate n inputs (n = 1..4)
//   _nY           gate n output, _nA & _nB delayed by DELAY_CYCLES edges
module dm74ls08_quad_and #(
    parameter int DELAY_CYCLES = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic _1A,
    input  logic _1B,
    output logic _1Y,
    input  logic _2A,
    input  logic _2B,
    output logic _2Y,
    input  logic _3A,
    input  logic _3B,
    output logic _3Y,
    input  logic _4A,
    input  logic _4B,
    output logic _4Y
);
    logic [3:0] ab;
    logic [3:0] y;
    assign ab = {_4A & _4B, _3A & _3B, _2A & _2B, _1A & _1B};
    assign {_4Y, _3Y, _2Y, _1Y} = y;
    generate
        if (DELAY_CYCLES == 0) begin : g_comb
            // clk and rst_n are deliberately inert in the drop-in configuration
            logic unused_ok;
            assign unused_ok = clk & rst_n;
            assign y = ab;
        end else begin : g_pipe
            // stage[i][n] holds gate n's AND result captured i edges ago
            logic [DELAY_CYCLES-1:0][3:0] stage;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    stage <= '0;
                end else begin
                    stage[0] <= ab;
                    for (int i = 1; i < DELAY_CYCLES; i++) stage[i] <= stage[i-1];
                end
            end
            assign y = stage[DELAY_CYCLES-1];
        end
    endgenerate
endmodule

// File: tb/tb_dm74ls08_quad_and.sv
// tb_dm74ls08_quad_and: scoreboard bench for the combinational, 1-cycle and 2-cycle variants
module tb_dm74ls08_quad_and;
    logic clk = 0;
    logic rst0_n, rst1_n, rst2_n;
    logic [3:0] a0, b0, a1, b1, a2, b2;
    logic [3:0] y0, y1, y2;
    logic [3:0] sb[$];
    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dm74ls08_quad_and #(.DELAY_CYCLES(0)) u_d0 (
        .clk(clk), .rst_n(rst0_n),
        ._1A(a0[0]), ._1B(b0[0]), ._1Y(y0[0]),
        ._2A(a0[1]), ._2B(b0[1]), ._2Y(y0[1]),
        ._3A(a0[2]), ._3B(b0[2]), ._3Y(y0[2]),
        ._4A(a0[3]), ._4B(b0[3]), ._4Y(y0[3])
    );
    dm74ls08_quad_and #(.DELAY_CYCLES(1)) u_d1 (
        .clk(clk), .rst_n(rst1_n),
        ._1A(a1[0]), ._1B(b1[0]), ._1Y(y1[0]),
        ._2A(a1[1]), ._2B(b1[1]), ._2Y(y1[1]),
        ._3A(a1[2]), ._3B(b1[2]), ._3Y(y1[2]),
        ._4A(a1[3]), ._4B(b1[3]), ._4Y(y1[3])
    );
    dm74ls08_quad_and #(.DELAY_CYCLES(2)) u_d2 (
        .clk(clk), .rst_n(rst2_n),
        ._1A(a2[0]), ._1B(b2[0]), ._1Y(y2[0]),
        ._2A(a2[1]), ._2B(b2[1]), ._2Y(y2[1]),
        ._3A(a2[2]), ._3B(b2[2]), ._3Y(y2[2]),
        ._4A(a2[3]), ._4B(b2[3]), ._4Y(y2[3])
    );

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic pop_check(input string tag, input logic [3:0] got);
        if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: scoreboard empty, got %b", tag, got);
        end else begin
            check(tag, got, sb.pop_front());
        end
    endtask

    task automatic edge1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        {a0, b0, a1, b1, a2, b2} = '0;
        {rst0_n, rst1_n, rst2_n} = '0;
        #2;
        check("d1_reset", y1, 4'h0);
        check("d2_reset", y2, 4'h0);
        #10;
        {rst0_n, rst1_n, rst2_n} = 3'b111;
        // DELAY_CYCLES=0: full truth table on all four gates
        for (int p = 0; p < 4; p++) begin
            a0 = {4{p[1]}};
            b0 = {4{p[0]}};
            sb.push_back(p == 3 ? 4'hF : 4'h0);
            #10;
            pop_check($sformatf("d0_tt_%0d", p), y0);
        end
        // gate independence, then the patterns mirrored across gates
        a0 = 4'b0101; b0 = 4'b0011; sb.push_back(4'b0001);
        #10 pop_check("d0_indep", y0);
        a0 = 4'b1010; b0 = 4'b1100; sb.push_back(4'b1000);
        #10 pop_check("d0_swap", y0);
        a0 = 4'b0110; b0 = 4'b1110; sb.push_back(4'b0110);
        #10 pop_check("d0_mix", y0);
        // reset has no effect on the combinational variant
        rst0_n = 0; a0 = 4'hF; b0 = 4'hF; sb.push_back(4'hF);
        #3 pop_check("d0_rst_low", y0);
        repeat (2) edge1;
        sb.push_back(4'hF);
        pop_check("d0_rst_clk", y0);
        rst0_n = 1;
        // DELAY_CYCLES=2 latency
        edge1;
        a2 = 4'hF; b2 = 4'hF;
        sb.push_back(4'h0); sb.push_back(4'hF);
        edge1; pop_check("d2_edge1", y2);
        edge1; pop_check("d2_edge2", y2);
        a2 = 4'h0;
        sb.push_back(4'hF); sb.push_back(4'h0);
        edge1; pop_check("d2_fall_edge1", y2);
        edge1; pop_check("d2_fall_edge2", y2);
        // async reset with outputs high
        a2 = 4'hF;
        repeat (2) edge1;
        sb.push_back(4'hF);
        pop_check("d2_pre_rst", y2);
        #2 rst2_n = 0;
        sb.push_back(4'h0);
        #1 pop_check("d2_rst_async", y2);
        sb.push_back(4'h0);
        edge1; pop_check("d2_rst_held", y2);
        #2 rst2_n = 1;
        sb.push_back(4'h0); sb.push_back(4'hF);
        edge1; pop_check("d2_rel_edge1", y2);
        edge1; pop_check("d2_rel_edge2", y2);
        // mid-flight reset discards the pipeline contents
        a2 = 4'h0;
        edge1;
        a2 = 4'hF;
        edge1;
        #2 rst2_n = 0;
        #2 rst2_n = 1;
        sb.push_back(4'h0);
        edge1; pop_check("d2_flush", y2);
        // DELAY_CYCLES=1: glitch between edges is swallowed
        b1 = 4'hF;
        edge1;
        #2 a1[0] = 1'b1;
        #5 a1[0] = 1'b0;
        sb.push_back(4'h0);
        edge1; pop_check("d1_glitch", y1);
        a1 = 4'b1001;
        sb.push_back(4'h0);
        #1 pop_check("d1_before_edge", y1);
        sb.push_back(4'b1001);
        edge1; pop_check("d1_after_edge", y1);
        #2 rst1_n = 0;
        sb.push_back(4'h0);
        #1 pop_check("d1_rst_async", y1);
        rst1_n = 1;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d entries left, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1, "timeout");
    end
endmodule
